// File: rtl/spi_rx_arb_pkg.sv
// Shared types and constants for the SPI receiver FIFO arbiter.
// The state enum and word/tag geometry are used by all arbiter files.
package spi_rx_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam int WORD_W  = 32;
  localparam int TAG_LSB = 24;
  localparam int TAG_W   = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request bit strictly after ptr,
// wrapping; ptr itself is tried last.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/spi_rx_fifo_arbiter.sv
// Round-robin merge of N FWFT source FIFOs into one FWFT output word.
// SPI_RX_ARB_SOURCE_TAG_EN stamps the source index into FIFO_DATA[27:24].
module spi_rx_fifo_arbiter
  import spi_rx_arb_pkg::*;
#(
  parameter int N_SOURCES = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST_N,
  input  logic [N_SOURCES-1:0]        SRC_ENABLE,
  input  logic [N_SOURCES-1:0]        SRC_FIFO_EMPTY,
  input  logic [WORD_W*N_SOURCES-1:0] SRC_FIFO_DATA,
  output logic [N_SOURCES-1:0]        SRC_FIFO_READ,
  input  logic                        FIFO_READ,
  output logic                        FIFO_EMPTY,
  output logic [WORD_W-1:0]           FIFO_DATA,
  output logic [3:0]                  GRANT_ID
);

  localparam int IW =
    (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t            state, state_nxt;
  logic              out_valid, out_valid_nxt;
  logic [WORD_W-1:0] data_q, data_nxt;
  logic [IW-1:0]     grant_q, grant_nxt;
  logic [IW-1:0]     rr_q, rr_nxt;
  logic [BW-1:0]     burst_q, burst_nxt;

  logic [N_SOURCES-1:0] req;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic                 avail;
  logic                 can_load;
  logic                 pop;
  logic [WORD_W-1:0]    words [N_SOURCES];
  logic [WORD_W-1:0]    src_word;
  logic [WORD_W-1:0]    load_word;

  assign req = SRC_ENABLE & ~SRC_FIFO_EMPTY;

  rr_pick #(
    .N  (N_SOURCES),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    for (int i = 0; i < N_SOURCES; i++) begin
      words[i] = SRC_FIFO_DATA[i*WORD_W +: WORD_W];
    end
  end

  assign src_word = words[grant_q];
  assign avail    = SRC_ENABLE[grant_q]
                  & ~SRC_FIFO_EMPTY[grant_q];
  assign can_load = ~out_valid | FIFO_READ;
  // No source is popped while reset is held.
  assign pop      = BUS_RST_N & (state == GRANT)
                  & can_load & avail;

  always_comb begin
    SRC_FIFO_READ          = '0;
    SRC_FIFO_READ[grant_q] = pop;
  end

`ifdef SPI_RX_ARB_SOURCE_TAG_EN
  always_comb begin
    load_word = src_word;
    load_word[TAG_LSB +: TAG_W] = TAG_W'(grant_q);
  end
`else
  assign load_word = src_word;
`endif

  always_comb begin
    state_nxt     = state;
    out_valid_nxt = out_valid;
    data_nxt      = data_q;
    grant_nxt     = grant_q;
    rr_nxt        = rr_q;
    burst_nxt     = burst_q;
    if (FIFO_READ && out_valid && !pop) begin
      out_valid_nxt = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          burst_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (pop) begin
          data_nxt      = load_word;
          out_valid_nxt = 1'b1;
          burst_nxt     = burst_q + 1'b1;
        end
        if (!avail ||
            (pop && burst_q == BW'(MAX_BURST - 1))) begin
          state_nxt = IDLE;
          rr_nxt    = grant_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      data_q    <= '0;
      grant_q   <= '0;
      rr_q      <= IW'(N_SOURCES - 1);
      burst_q   <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      data_q    <= data_nxt;
      grant_q   <= grant_nxt;
      rr_q      <= rr_nxt;
      burst_q   <= burst_nxt;
    end
  end

  assign FIFO_EMPTY = ~out_valid;
  assign FIFO_DATA  = data_q;
  assign GRANT_ID   = 4'(grant_q);

endmodule

// File: tb/tb_spi_rx_fifo_arbiter.sv
// Scoreboard bench: two arbiters (MAX_BURST 8 and 2) fed by
// model source FIFOs; a monitor pops expected words on each read.
module tb_spi_rx_fifo_arbiter;
  import spi_rx_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  en     [2];
  logic        fread  [2];
  logic        clr    [2];
  logic [31:0] mem    [2][4][32];
  int          tail   [2][4];
  logic [3:0]  rd     [2];
  logic [3:0]  gid    [2];
  logic        fempty [2];
  logic [31:0] fdata  [2];
  logic [31:0] expq   [2][$];

  int   checks = 0;
  int   errors = 0;
  logic watch4 = 1'b0;
  logic saw_g1 = 1'b0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int MB = (d == 0) ? 8 : 2;
    logic [3:0]   empty;
    logic [127:0] data;
    int           head [4] = '{default: 0};
    int           pops [4] = '{default: 0};
    logic [31:0]  e_w;

    always_comb begin
      empty = '0;
      data  = '0;
      for (int s = 0; s < 4; s++) begin
        empty[s] = (head[s] == tail[d][s]);
        data[32*s +: 32] = mem[d][s][head[s][4:0]];
      end
    end

    always @(posedge clk) begin
      for (int s = 0; s < 4; s++) begin
        if (clr[d]) begin
          head[s] <= 0;
        end else if (rd[d][s]) begin
          head[s] <= head[s] + 1;
          pops[s] <= pops[s] + 1;
        end
      end
    end

    spi_rx_fifo_arbiter #(
      .N_SOURCES (4),
      .MAX_BURST (MB)
    ) u_dut (
      .BUS_CLK        (clk),
      .BUS_RST_N      (rst_n),
      .SRC_ENABLE     (en[d]),
      .SRC_FIFO_EMPTY (empty),
      .SRC_FIFO_DATA  (data),
      .SRC_FIFO_READ  (rd[d]),
      .FIFO_READ      (fread[d]),
      .FIFO_EMPTY     (fempty[d]),
      .FIFO_DATA      (fdata[d]),
      .GRANT_ID       (gid[d])
    );

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (fread[d] && fempty[d] === 1'b0) begin
          checks++;
          if (expq[d].size() == 0) begin
            errors++;
            $display("FAIL dut%0d word: got %h, required none",
                     d, fdata[d]);
          end else begin
            e_w = expq[d].pop_front();
            if (fdata[d] !== e_w) begin
              errors++;
              $display("FAIL dut%0d word: got %h, required %h",
                       d, fdata[d], e_w);
            end
          end
        end
        if (rd[d] != 4'b0) begin
          checks++;
          if (!$onehot(rd[d]) || (rd[d] & empty) != 4'b0) begin
            errors++;
            $display("FAIL dut%0d pop: got rd=%b empty=%b",
                     d, rd[d], empty);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (watch4 && gid[0] == 4'd1) saw_g1 = 1'b1;
  end

  function automatic logic [31:0] tagw(input int s,
                                       input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef SPI_RX_ARB_SOURCE_TAG_EN
    r[27:24] = 4'(s);
`endif
    return r;
  endfunction

  task automatic push(input int d, input int s,
                      input logic [31:0] w, input bit ex);
    mem[d][s][tail[d][s] % 32] = w;
    tail[d][s]++;
    if (ex) expq[d].push_back(tagw(s, w));
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int p;
  int e1 [6] = '{1, 1, 0, 0, 0, 1};
  logic [31:0] ord2 [8];

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = '0; fread[d] = 1'b0; clr[d] = 1'b0;
      for (int s = 0; s < 4; s++) tail[d][s] = 0;
    end

    // t1: three words from src0 with read held high
    en[0] = 4'b0001; fread[0] = 1'b1;
    push(0, 0, 32'h1000_00A0, 1);
    push(0, 0, 32'h1000_00A1, 1);
    push(0, 0, 32'h1000_00A2, 1);
    tick(3);
    @(negedge clk);
    check("rst empty", 32'(fempty[0]), 1);
    check("rst data", fdata[0], 0);
    check("rst gid", 32'(gid[0]), 0);
    check("rst pop", 32'(rd[0]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      check($sformatf("t1 empty@%0d", k),
            32'(fempty[0]), 32'(e1[k]));
    end
    check("t1 pops0", 32'(g_dut[0].pops[0]), 3);
    check("t1 pops123", 32'(g_dut[0].pops[1] +
          g_dut[0].pops[2] + g_dut[0].pops[3]), 0);

    // t2: burst of 2, two sources interleave
    en[1] = 4'b0011; fread[1] = 1'b1;
    ord2 = '{32'hA0, 32'hA1, 32'hB0, 32'hB1,
             32'hA2, 32'hA3, 32'hB2, 32'hB3};
    for (int i = 0; i < 4; i++) begin
      push(1, 0, 32'hA0 + 32'(i), 0);
      push(1, 1, 32'hB0 + 32'(i), 0);
    end
    for (int i = 0; i < 8; i++)
      expq[1].push_back(tagw(i == 2 || i == 3 ||
                             i == 6 || i == 7 ? 1 : 0, ord2[i]));
    tick(24);
    check("t2 drained", 32'(expq[1].size()), 0);

    // t3: backpressure holds the word, one read = one pop
    fread[0] = 1'b0;
    p = g_dut[0].pops[0];
    for (int i = 0; i < 4; i++)
      push(0, 0, 32'hD000_0000 + 32'(i), 1);
    tick(5);
    @(negedge clk);
    check("t3 load pops", 32'(g_dut[0].pops[0] - p), 1);
    check("t3 held", fdata[0], tagw(0, 32'hD000_0000));
    check("t3 valid", 32'(fempty[0]), 0);
    tick(3);
    @(negedge clk);
    check("t3 hold pops", 32'(g_dut[0].pops[0] - p), 1);
    check("t3 stable", fdata[0], tagw(0, 32'hD000_0000));
    @(posedge clk); #1 fread[0] = 1'b1;
    @(posedge clk); #1 fread[0] = 1'b0;
    @(negedge clk);
    check("t3 one pop", 32'(g_dut[0].pops[0] - p), 2);
    check("t3 next", fdata[0], tagw(0, 32'hD000_0001));
    fread[0] = 1'b1;
    tick(8);
    check("t3 drained", 32'(expq[0].size()), 0);

    // t4: src1 masked off
    en[0] = 4'b1101; watch4 = 1'b1;
    p = g_dut[0].pops[1];
    push(0, 1, 32'hBAD0_0000, 0);
    push(0, 1, 32'hBAD0_0001, 0);
    push(0, 0, 32'hC0, 0); push(0, 0, 32'hC1, 0);
    push(0, 2, 32'hE0, 0); push(0, 2, 32'hE1, 0);
    push(0, 3, 32'hF0, 0); push(0, 3, 32'hF1, 0);
    expq[0].push_back(tagw(2, 32'hE0));
    expq[0].push_back(tagw(2, 32'hE1));
    expq[0].push_back(tagw(3, 32'hF0));
    expq[0].push_back(tagw(3, 32'hF1));
    expq[0].push_back(tagw(0, 32'hC0));
    expq[0].push_back(tagw(0, 32'hC1));
    tick(24);
    watch4 = 1'b0;
    check("t4 gid1 seen", 32'(saw_g1), 0);
    check("t4 src1 pops", 32'(g_dut[0].pops[1] - p), 0);
    check("t4 drained", 32'(expq[0].size()), 0);
    en[0] = 4'b0000;
    tick(1);
    clr[0] = 1'b1;
    for (int s = 0; s < 4; s++) tail[0][s] = 0;
    tick(1);
    clr[0] = 1'b0;

    // t6: source tag on src2
    en[0] = 4'b0100;
    push(0, 2, 32'hA5A5_A5A5, 0);
`ifdef SPI_RX_ARB_SOURCE_TAG_EN
    expq[0].push_back(32'hA2A5_A5A5);
`else
    expq[0].push_back(32'hA5A5_A5A5);
`endif
    tick(8);
    check("t6 drained", 32'(expq[0].size()), 0);

    // t5: reset in the middle of a burst
    en[0] = 4'b0011;
    for (int i = 0; i < 8; i++)
      push(0, 0, 32'h6000_0000 + 32'(i), i < 2);
    tick(4);
    rst_n = 1'b0;
    push(0, 1, 32'h7000_0000, 0);
    @(negedge clk);
    check("t5 pop in rst", 32'(rd[0]), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5 empty", 32'(fempty[0]), 1);
    check("t5 pop", 32'(rd[0]), 0);
    check("t5 state", 32'(g_dut[0].u_dut.state), 32'(IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 3; i < 8; i++)
      expq[0].push_back(tagw(0, 32'h6000_0000 + 32'(i)));
    expq[0].push_back(tagw(1, 32'h7000_0000));
    @(posedge clk);
    @(negedge clk);
    check("t5 regrant", 32'(rd[0]), 32'h1);
    tick(20);
    check("t5 drained", 32'(expq[0].size()), 0);
    check("dut1 idle", 32'(expq[1].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
